axi_mem_slave: RTL and testbench
================================

Name: axi_mem_slave

Overview:
AXI4 memory-mapped responder (slave) that serves as the downstream end of the cache's AXI master port. It serves AW/W/B and AR/R transactions from an internal word-addressed RAM. It supports INCR and FIXED bursts up to 256 beats, with one outstanding transaction at a time. It is the memory model behind the cache in unit and integration benches, and is synthesizable as a small on-chip backing store.

Parameters:
AXI_ADDR_WIDTH, 32, byte address width
AXI_DATA_WIDTH, 64, data width; fixed 8-byte beats
AXI_ID_WIDTH, 4, transaction ID width
MEM_DEPTH, 1024, RAM depth in AXI_DATA_WIDTH words; power of two
RD_STALL, 2, wait cycles before each read beat (used only under the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWID  in  AXI_ID_WIDTH  write ID
S_AXI_AWBURST  in  2  burst type
S_AXI_AWSIZE  in  3  beat size
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  AXI_DATA_WIDTH  write data
S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WLAST  in  1  last write beat
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BID  out  AXI_ID_WIDTH  response ID
S_AXI_BREADY  in  1  response ready
S_AXI_ARADDR / ARVALID / ARID / ARBURST / ARSIZE / ARLEN  in  as the AW channel  read address channel
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  AXI_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read valid
S_AXI_RID  out  AXI_ID_WIDTH  read ID
S_AXI_RLAST  out  1  last read beat
S_AXI_RREADY  in  1  read ready

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst.
- Reset values: state=IDLE; AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0; RDATA, BRESP, RRESP, BID and RID are 0. RAM contents are not reset.
- States:
  - IDLE: AWREADY=1; ARREADY = !AWVALID. Writes take priority when AWVALID and ARVALID are asserted in the same cycle.
  - W_DATA: entered on AW handshake; latches addr, id, len, burst.
  - W_RESP: entered after the last write beat.
  - R_DATA: entered on AR handshake; latches addr, id, len, burst.
  - Leaving W_RESP or R_DATA returns to IDLE.
- Indexing:
  - Word index = addr[3 +: clog2(MEM_DEPTH)].
  - Address is out of range if any bit above the index field is nonzero.
  - INCR adds 8 per beat; the index wraps modulo MEM_DEPTH.
  - FIXED holds the address.
  - WRAP, or SIZE != 3, sets the error flag: SLVERR for the whole burst, with no RAM writes and read data 0.
- Write path:
  - WREADY=1 in W_DATA.
  - Each W handshake writes the strobed bytes and increments the beat counter.
  - Burst ends when beat counter == len, regardless of WLAST.
  - If WLAST disagrees with counter==len on any beat, the burst completes with BRESP=SLVERR; strobed bytes are still written.
  - Out of range: writes are dropped and BRESP=DECERR. DECERR overrides SLVERR.
- Write response: BVALID rises the cycle after the last W handshake, with BID = latched id. It holds stable until BREADY, then the block returns to IDLE.
- Read path:
  - RVALID rises exactly 1 cycle after the AR handshake; RDATA is a registered RAM read.
  - While RREADY stays high, one beat per cycle.
  - RDATA, RRESP, RLAST and RID hold stable while RVALID=1 and RREADY=0.
  - RLAST=1 on beat len.
  - Out-of-range beats return RRESP=DECERR with RDATA=0. Range is evaluated per beat, so an INCR burst crossing the limit mixes OKAY and DECERR beats.
- Ordering: no new AW or AR is accepted until the current transaction completes (B handshake, or R handshake with RLAST).
- Reset mid-burst: abort immediately and return to IDLE. A partially written burst keeps the beats already written; no B or R response is issued for it.

Optional Feature:
AXI_MEM_RD_STALL_EN
- Defined: RVALID deasserts for RD_STALL cycles before every read beat, including the first. The first beat arrives 1+RD_STALL cycles after the AR handshake.
- Undefined: no stall logic is built and the base latency applies.

Decomposition:
- Package axi_mem_pkg holds:
  - the state enum;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - BURST_FIXED/INCR/WRAP;
  - SIZE_8B.
- One sub-module, axi_mem_ram: single-port byte-enable RAM with registered read.

Test Plan:
- Single write 0x40, data 0x1122334455667788, strobe 0xFF, then read 0x40 -> BRESP OKAY; RDATA matches; RLAST=1; RVALID 1 cycle after AR handshake.
- INCR write AWLEN=3 at 0x100 with strobe 0x0F on beat 2 -> read of 4 beats returns only the low 4 bytes updated on beat 2; RLAST only on beat 3; BID/RID echo 0x5.
- AWVALID and ARVALID in the same cycle -> AW accepted, ARREADY=0; read served after the B handshake.
- Address 0x2000 (MEM_DEPTH=1024) -> write dropped with BRESP DECERR; read returns RDATA=0 with RRESP DECERR.
- WLAST on beat 1 with AWLEN=3 -> 4 beats consumed, BRESP SLVERR. Separately, RREADY held low 5 cycles mid-burst -> read outputs stable throughout.
- Reset asserted in W_DATA after 2 of 4 beats -> next cycle AWREADY=1, BVALID=0; those 2 beats remain in RAM.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared types and constants for the AXI4 memory responder.
//   state_t      - transaction FSM states
//   RESP_*       - AXI response codes
//   BURST_*      - AXI burst type encodings
//   SIZE_8B      - the only supported beat size (8 bytes)
package axi_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2,
        R_DATA = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_8B = 3'd3;

    // DECERR outranks SLVERR, which outranks OKAY.
    function automatic logic [1:0] resp_code(input logic dec, input logic slv);
        return dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: single-port RAM with per-byte write enables and a registered
// read port. Contents are not reset.
//   clk   - clock
//   we    - write enable, be selects the bytes written
//   re    - read enable; rdata holds its value while re is low
//   addr  - word index shared by read and write
//   wdata - write data
//   rdata - registered read data
module axi_mem_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 memory-mapped responder backed by an on-chip RAM.
// Serves one AW/W/B or AR/R transaction at a time, INCR and FIXED bursts of
// up to 256 eight-byte beats. WRAP bursts and sizes other than 8 bytes answer
// SLVERR without touching the RAM; addresses beyond MEM_DEPTH words answer
// DECERR per beat.
//
// Ports: clk, rst (synchronous, active-high); S_AXI_AW* write address,
// S_AXI_W* write data, S_AXI_B* write response, S_AXI_AR* read address,
// S_AXI_R* read data.
//
// Build option: define AXI_MEM_RD_STALL_EN to hold RVALID low for RD_STALL
// cycles before every read beat. Without it, read beats follow back to back.
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 1024,
    parameter int RD_STALL       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                        S_AXI_AWVALID,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic [2:0]                  S_AXI_AWSIZE,
    input  logic [7:0]                  S_AXI_AWLEN,
    output logic                        S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                        S_AXI_WVALID,
    input  logic                        S_AXI_WLAST,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
    input  logic                        S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic [2:0]                  S_AXI_ARSIZE,
    input  logic [7:0]                  S_AXI_ARLEN,
    output logic                        S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
    output logic                        S_AXI_RLAST,
    input  logic                        S_AXI_RREADY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    if (AXI_DATA_WIDTH != 64) begin : g_bad_width
        $error("axi_mem_slave supports 8-byte beats only");
    end
    if ((1 << IDX_W) != MEM_DEPTH) begin : g_bad_depth
        $error("MEM_DEPTH must be a power of two");
    end
    if (RD_STALL < 0 || RD_STALL > 255) begin : g_bad_stall
        $error("RD_STALL must be in 0..255");
    end

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
        return a[3 +: IDX_W];
    endfunction

    // Any address bit above the word index field puts the beat outside the RAM.
    function automatic logic addr_oor(input logic [AXI_ADDR_WIDTH-1:0] a);
        return |(a >> (3 + IDX_W));
    endfunction

    // Full-width add: the word index wraps, and a carry into the upper bits
    // makes later beats of the burst out of range.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                           input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + AXI_ADDR_WIDTH'(8) : a;
    endfunction

    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == BURST_FIXED || burst == BURST_INCR) || (size != SIZE_8B);
    endfunction

    state_t state_q, state_d;

    logic                      awready, wready, arready;
    logic                      bvalid_q, rvalid_q, rlast_q, rdata_ok_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      wslv_q, wdec_q;

    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q, beat_q;
    logic [1:0]                burst_q;
    logic                      err_q;

    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                      w_final, wlast_mism, rd_adv, rd_issue;
    logic [AXI_ADDR_WIDTH-1:0] rd_issue_addr;
    logic                      rd_issue_err, rd_issue_last;

    logic                      ram_we;
    logic [IDX_W-1:0]          ram_addr;
    logic [AXI_DATA_WIDTH-1:0] ram_rdata;

    assign aw_hs      = awready && S_AXI_AWVALID;
    assign ar_hs      = arready && S_AXI_ARVALID;
    assign w_hs       = wready && S_AXI_WVALID;
    assign b_hs       = bvalid_q && S_AXI_BREADY;
    assign r_hs       = rvalid_q && S_AXI_RREADY;

    // The beat counter, not WLAST, decides where a write burst ends.
    assign w_final    = (beat_q == len_q);
    assign wlast_mism = (S_AXI_WLAST != w_final);

    // A read beat is fetched on the AR handshake and on every accepted
    // non-final beat; the RAM output register then holds it until accepted.
    assign rd_adv        = (state_q == R_DATA) && r_hs && !rlast_q;
    assign rd_issue      = ar_hs || rd_adv;
    assign rd_issue_addr = ar_hs ? S_AXI_ARADDR : next_addr(addr_q, burst_q);
    assign rd_issue_err  = ar_hs ? burst_bad(S_AXI_ARBURST, S_AXI_ARSIZE) : err_q;
    assign rd_issue_last = ar_hs ? (S_AXI_ARLEN == 8'd0) : (beat_q + 8'd1 == len_q);

    assign ram_we   = w_hs && !err_q && !addr_oor(addr_q);
    assign ram_addr = (state_q == W_DATA) ? word_idx(addr_q) : word_idx(rd_issue_addr);

    axi_mem_ram #(
        .DATA_W (AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (S_AXI_WSTRB),
        .re    (rd_issue),
        .addr  (ram_addr),
        .wdata (S_AXI_WDATA),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        case (state_q)
            IDLE: begin
                awready = !rst;
                arready = !rst && !S_AXI_AWVALID;
                if (S_AXI_AWVALID)      state_d = W_DATA;
                else if (S_AXI_ARVALID) state_d = R_DATA;
            end
            W_DATA: begin
                wready = !rst;
                if (S_AXI_WVALID && w_final) state_d = W_RESP;
            end
            W_RESP: begin
                if (S_AXI_BREADY) state_d = IDLE;
            end
            R_DATA: begin
                if (rvalid_q && S_AXI_RREADY && rlast_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef AXI_MEM_RD_STALL_EN
    logic [7:0] stall_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_ok_q <= 1'b0;
            id_q       <= '0;
            wslv_q     <= 1'b0;
            wdec_q     <= 1'b0;
`ifdef AXI_MEM_RD_STALL_EN
            stall_q    <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q   <= S_AXI_AWID;
                wslv_q <= burst_bad(S_AXI_AWBURST, S_AXI_AWSIZE);
                wdec_q <= 1'b0;
            end
            if (ar_hs) id_q <= S_AXI_ARID;
            if (w_hs) begin
                wslv_q <= wslv_q | wlast_mism;
                wdec_q <= wdec_q | addr_oor(addr_q);
                if (w_final) begin
                    bvalid_q <= 1'b1;
                    bresp_q  <= resp_code(wdec_q | addr_oor(addr_q), wslv_q | wlast_mism);
                end
            end
            if (b_hs) bvalid_q <= 1'b0;
            if (rd_issue) begin
                rlast_q    <= rd_issue_last;
                rresp_q    <= resp_code(addr_oor(rd_issue_addr), rd_issue_err);
                rdata_ok_q <= !addr_oor(rd_issue_addr) && !rd_issue_err;
`ifdef AXI_MEM_RD_STALL_EN
                rvalid_q   <= (RD_STALL == 0);
                stall_q    <= 8'(RD_STALL);
`else
                rvalid_q   <= 1'b1;
`endif
            end else if (r_hs && rlast_q) begin
                rvalid_q <= 1'b0;
            end
`ifdef AXI_MEM_RD_STALL_EN
            else if (state_q == R_DATA && !rvalid_q && stall_q != 8'd0) begin
                stall_q <= stall_q - 8'd1;
                if (stall_q == 8'd1) rvalid_q <= 1'b1;
            end
`endif
        end
    end

    // Burst bookkeeping shared by both directions; only one is ever active.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            addr_q  <= S_AXI_AWADDR;
            len_q   <= S_AXI_AWLEN;
            burst_q <= S_AXI_AWBURST;
            err_q   <= burst_bad(S_AXI_AWBURST, S_AXI_AWSIZE);
            beat_q  <= 8'd0;
        end else if (ar_hs) begin
            addr_q  <= S_AXI_ARADDR;
            len_q   <= S_AXI_ARLEN;
            burst_q <= S_AXI_ARBURST;
            err_q   <= burst_bad(S_AXI_ARBURST, S_AXI_ARSIZE);
            beat_q  <= 8'd0;
        end else if (w_hs || rd_adv) begin
            addr_q  <= next_addr(addr_q, burst_q);
            beat_q  <= beat_q + 8'd1;
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BID     = id_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RID     = id_q;
    assign S_AXI_RDATA   = rdata_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Testbench for axi_mem_slave (default build). A word array mirrors the RAM;
// expected responses, data and RLAST are derived from burst arithmetic.
module tb_axi_mem_slave;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, arvalid, awready, arready;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [2:0]    awsize, arsize;
    logic [7:0]    awlen, arlen;
    logic [DW-1:0] wdata, rdata;
    logic [7:0]    wstrb;
    logic          wvalid, wlast, wready, bvalid, bready, rvalid, rlast, rready;

    always #5 clk = ~clk;

    axi_mem_slave #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .MEM_DEPTH      (DEPTH),
        .RD_STALL       (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWID    (awid),
        .S_AXI_AWBURST (awburst),
        .S_AXI_AWSIZE  (awsize),
        .S_AXI_AWLEN   (awlen),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WLAST   (wlast),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BID     (bid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARID    (arid),
        .S_AXI_ARBURST (arburst),
        .S_AXI_ARSIZE  (arsize),
        .S_AXI_ARLEN   (arlen),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RID     (rid),
        .S_AXI_RLAST   (rlast),
        .S_AXI_RREADY  (rready)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem_m [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_oor(input logic [31:0] a);
        return longint'(a) >= longint'(DEPTH) * 8;
    endfunction

    function automatic bit m_bad(input logic [1:0] burst, input logic [2:0] size);
        return !(burst == 2'b00 || burst == 2'b01) || size != 3'd3;
    endfunction

    function automatic logic [31:0] m_beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b01) ? a + 32'(8 * i) : a;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 8) % DEPTH);
    endfunction

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                               input logic [2:0] size, input int len, input int strb_mode,
                               input int wlast_beat, input int abort_after, input bit with_ar,
                               input bit use_fixed, input logic [63:0] fdata);
        bit          any_oor = 0;
        bit          mism    = 0;
        bit          isbad;
        int          n;
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic [1:0]  exp_resp;
        isbad   = m_bad(burst, size);
        awaddr  = addr; awid = id; awburst = burst; awsize = size; awlen = 8'(len);
        awvalid = 1'b1;
        if (with_ar) begin
            araddr = addr; arid = id; arburst = 2'b01; arsize = 3'd3; arlen = 8'd0;
            arvalid = 1'b1;
        end
        #1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        chk("awready", awready, 1);
        if (with_ar) chk("arready_blocked_by_aw", arready, 0);
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_after) begin
                wvalid = 1'b0;
                rst    = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("abort_awready", awready, 1);
                chk("abort_bvalid", bvalid, 0);
                return;
            end
            a = m_beat_addr(addr, burst, i);
            d = use_fixed ? fdata + 64'(i) : {$urandom, $urandom};
            s = (strb_mode == 0) ? 8'hFF : (strb_mode == 1) ? 8'($urandom) : ((i == 2) ? 8'h0F : 8'hFF);
            wdata  = d;
            wstrb  = s;
            wlast  = (wlast_beat < 0) ? (i == len) : (i == wlast_beat);
            wvalid = 1'b1;
            if (wlast != (i == len)) mism = 1;
            if (m_oor(a)) any_oor = 1;
            else if (!isbad) begin
                for (int b = 0; b < 8; b++)
                    if (s[b]) mem_m[m_idx(a)][8*b +: 8] = d[8*b +: 8];
            end
            #1;
            chk("wready", wready, 1);
            chk("bvalid_before_last", bvalid, 0);
            if (with_ar) chk("arready_in_w", arready, 0);
            @(posedge clk);
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        exp_resp = any_oor ? 2'b11 : ((isbad || mism) ? 2'b10 : 2'b00);
        #1;
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, exp_resp);
        chk("bid", bid, id);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, exp_resp);
            if (with_ar) chk("arready_in_wresp", arready, 0);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("bvalid_clear", bvalid, 0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [1:0] burst,
                              input logic [2:0] size, input int len, input int stall_beat, input int stall_len);
        int          n;
        logic [31:0] a;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        bit          isbad;
        isbad   = m_bad(burst, size);
        araddr  = addr; arid = id; arburst = burst; arsize = size; arlen = 8'(len);
        arvalid = 1'b1;
        rready  = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        chk("arready", arready, 1);
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a        = m_beat_addr(addr, burst, i);
            exp_resp = m_oor(a) ? 2'b11 : (isbad ? 2'b10 : 2'b00);
            exp_data = (m_oor(a) || isbad) ? 64'd0 : mem_m[m_idx(a)];
            #1;
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, exp_data);
            chk("rresp", rresp, exp_resp);
            chk("rlast", rlast, (i == len) ? 1 : 0);
            chk("rid", rid, id);
            if (i == stall_beat) begin
                rready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk); #1;
                    chk("rvalid_stall", rvalid, 1);
                    chk("rdata_stall", rdata, exp_data);
                    chk("rresp_stall", rresp, exp_resp);
                    chk("rlast_stall", rlast, (i == len) ? 1 : 0);
                    chk("rid_stall", rid, id);
                end
                rready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; awvalid = 0; awid = '0; awburst = 2'b01; awsize = 3'd3; awlen = '0;
        araddr = '0; arvalid = 0; arid = '0; arburst = 2'b01; arsize = 3'd3; arlen = '0;
        wdata = '0; wstrb = '0; wvalid = 0; wlast = 0; bready = 0; rready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);
        @(negedge clk);

        // Fill the whole RAM so every later read has a known expectation.
        for (int k = 0; k < 4; k++)
            write_burst(32'(k * 2048), 4'd0, 2'b01, 3'd3, 255, 0, -1, -1, 0, 0, 64'd0);

        // Single beat write then read.
        write_burst(32'h40, 4'd1, 2'b01, 3'd3, 0, 0, -1, -1, 0, 1, 64'h1122334455667788);
        read_burst(32'h40, 4'd1, 2'b01, 3'd3, 0, -1, 0);

        // INCR x4, partial strobe on beat 2, ID echo.
        write_burst(32'h100, 4'd5, 2'b01, 3'd3, 3, 2, -1, -1, 0, 0, 64'd0);
        read_burst(32'h100, 4'd5, 2'b01, 3'd3, 3, -1, 0);

        // AW and AR together: write wins, read follows the B handshake.
        write_burst(32'h200, 4'd3, 2'b01, 3'd3, 1, 0, -1, -1, 1, 0, 64'd0);
        read_burst(32'h200, 4'd3, 2'b01, 3'd3, 0, -1, 0);

        // Out of range.
        write_burst(32'h2000, 4'd2, 2'b01, 3'd3, 0, 0, -1, -1, 0, 0, 64'd0);
        read_burst(32'h2000, 4'd2, 2'b01, 3'd3, 0, -1, 0);

        // Early WLAST, then a read with RREADY low for 5 cycles mid-burst.
        write_burst(32'h300, 4'd6, 2'b01, 3'd3, 3, 1, 1, -1, 0, 0, 64'd0);
        read_burst(32'h300, 4'd6, 2'b01, 3'd3, 7, 2, 5);

        // Reset after 2 of 4 beats.
        write_burst(32'h400, 4'd7, 2'b01, 3'd3, 3, 0, -1, 2, 0, 0, 64'd0);
        read_burst(32'h400, 4'd7, 2'b01, 3'd3, 3, -1, 0);

        // INCR read crossing the top of the RAM.
        read_burst(32'h1FF0, 4'd8, 2'b01, 3'd3, 3, -1, 0);

        // WRAP and bad size: SLVERR, no writes, zero read data.
        write_burst(32'h500, 4'd9, 2'b10, 3'd3, 3, 0, -1, -1, 0, 0, 64'd0);
        read_burst(32'h500, 4'd9, 2'b01, 3'd3, 3, -1, 0);
        read_burst(32'h500, 4'd9, 2'b10, 3'd3, 1, -1, 0);
        read_burst(32'h508, 4'd9, 2'b01, 3'd2, 0, -1, 0);

        // FIXED burst: every beat lands on one word.
        write_burst(32'h600, 4'd10, 2'b00, 3'd3, 3, 1, -1, -1, 0, 0, 64'd0);
        read_burst(32'h600, 4'd10, 2'b00, 3'd3, 2, -1, 0);

        // Randomized in-range bursts.
        for (int t = 0; t < 10; t++) begin
            logic [31:0] ra;
            logic [1:0]  rb;
            logic [3:0]  rd_id;
            int          rl;
            rl    = int'($urandom_range(0, 15));
            rb    = 2'($urandom_range(0, 1));
            ra    = 32'($urandom_range(0, DEPTH - 17)) * 8;
            rd_id = 4'($urandom);
            write_burst(ra, rd_id, rb, 3'd3, rl, 1, -1, -1, 0, 0, 64'd0);
            read_burst(ra, rd_id, rb, 3'd3, rl, int'($urandom_range(0, rl)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
